// File: rtl/crc16_frame_arb_if.sv
// Requester, output-stream and error signals of the two-channel CRC frame arbiter.
// The master side is the arbiter itself; the slave side is its environment.
interface crc16_frame_arb_if;
  logic [7:0] in0_data;
  logic       in0_valid;
  logic       in0_last;
  logic       in0_ready;
  logic [7:0] in1_data;
  logic       in1_valid;
  logic       in1_last;
  logic       in1_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_chan;
  logic       out_ready;
  logic       err_trunc;

  modport master (
    input  in0_data, in0_valid, in0_last, in1_data, in1_valid, in1_last, out_ready,
    output in0_ready, in1_ready, out_data, out_valid, out_last, out_chan, err_trunc
  );

  modport slave (
    output in0_data, in0_valid, in0_last, in1_data, in1_valid, in1_last, out_ready,
    input  in0_ready, in1_ready, out_data, out_valid, out_last, out_chan, err_trunc
  );
endinterface

// File: rtl/crc16_frame_arb.sv
// Round-robin two-channel frame arbiter with inline CRC-16 and trailing inverted CRC bytes.
// Overlong frames are cut at MAX_LEN, closed with a CRC and the remainder is dropped.
module crc16_frame_arb #(
  parameter logic [15:0] POLYNOMIAL = 16'h8005,
  parameter logic [15:0] INIT_VALUE = 16'hFFFF,
  parameter int unsigned MAX_LEN    = 1024
) (
  input  logic              clk_in,
  input  logic              rst_n,
  crc16_frame_arb_if.master bus
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PAYLOAD = 3'd1,
    S_CRC_HI  = 3'd2,
    S_CRC_LO  = 3'd3,
    S_DROP    = 3'd4
  } state_t;

  state_t           state;
  logic             grant;
  logic             last_grant;
  logic [15:0]      crc;
  logic [CNT_W-1:0] count;
  logic             trunc;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_chan;
  logic             err_trunc;

  logic             slot_free_c;
  logic             ready0_c;
  logic             ready1_c;
  logic             sel_valid_c;
  logic             sel_last_c;
  logic [7:0]       sel_data_c;
  logic             accept_c;
  logic             pick_c;
  logic             len_hit_c;

  // MSB-first, non-reflected CRC update over one byte
  function automatic logic [15:0] crc_next(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ POLYNOMIAL) : (r << 1);
    end
    return r;
  endfunction

  // Handshake decode, channel mux and arbitration choice
  always_comb begin
    slot_free_c = !out_valid || bus.out_ready;
    ready0_c    = 1'b0;
    ready1_c    = 1'b0;
    sel_valid_c = grant ? bus.in1_valid : bus.in0_valid;
    sel_last_c  = grant ? bus.in1_last  : bus.in0_last;
    sel_data_c  = grant ? bus.in1_data  : bus.in0_data;
    case (state)
      S_PAYLOAD: begin
        ready0_c = !grant && slot_free_c;
        ready1_c = grant && slot_free_c;
      end
      S_DROP: begin
        ready0_c = !grant;
        ready1_c = grant;
      end
      default: ;
    endcase
    accept_c  = sel_valid_c && (grant ? ready1_c : ready0_c);
    pick_c    = (bus.in0_valid && bus.in1_valid) ? !last_grant : bus.in1_valid;
    len_hit_c = ({1'b0, count} + 17'd1) == 17'(MAX_LEN);
  end

  assign bus.in0_ready = ready0_c;
  assign bus.in1_ready = ready1_c;
  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_chan  = out_chan;
  assign bus.err_trunc = err_trunc;

  // Frame sequencer with registered output stage
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      crc        <= INIT_VALUE;
      count      <= '0;
      trunc      <= 1'b0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_chan   <= 1'b0;
      err_trunc  <= 1'b0;
    end else begin
      err_trunc <= 1'b0;
      if (out_valid && bus.out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (bus.in0_valid || bus.in1_valid) begin
            grant      <= pick_c;
            last_grant <= pick_c;
            crc        <= INIT_VALUE;
            count      <= '0;
            state      <= S_PAYLOAD;
            // a stalled CRC byte of the previous frame keeps its channel tag
            if (slot_free_c) begin
              out_chan <= pick_c;
            end
          end
        end
        S_PAYLOAD: begin
          if (accept_c) begin
            out_data  <= sel_data_c;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            out_chan  <= grant;
            crc       <= crc_next(crc, sel_data_c);
            count     <= count + CNT_W'(1);
            if (sel_last_c) begin
              state <= S_CRC_HI;
            end else if (len_hit_c) begin
              state     <= S_CRC_HI;
              trunc     <= 1'b1;
              err_trunc <= 1'b1;
            end
          end
        end
        S_CRC_HI: begin
          if (slot_free_c) begin
            out_data  <= ~crc[15:8];
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            state     <= S_CRC_LO;
          end
        end
        S_CRC_LO: begin
          if (slot_free_c) begin
            out_data  <= ~crc[7:0];
            out_valid <= 1'b1;
            out_last  <= 1'b1;
            state     <= trunc ? S_DROP : S_IDLE;
          end
        end
        S_DROP: begin
          if (accept_c && sel_last_c) begin
            trunc <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc16_frame_arb.sv
// Bench for crc16_frame_arb: three instances (default, MAX_LEN=4, poly 0x1021) with a
// per-channel byte scoreboard fed by a frame-level reference model.
module tb_crc16_frame_arb;

  localparam int NI = 3;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       chan;
  } obs_t;

  typedef struct {
    int         inst;
    logic       chan;
    logic       bp;
    logic [7:0] hi;
    logic [7:0] lo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] in_data  [NI][2];
  logic       in_valid [NI][2];
  logic       in_last  [NI][2];
  logic       out_rdy  [NI];
  logic       rdy      [NI][2];
  logic [7:0] o_data   [NI];
  logic       o_valid  [NI];
  logic       o_last   [NI];
  logic       o_chan   [NI];
  logic       o_err    [NI];

  for (genvar g = 0; g < NI; g++) begin : gi
    crc16_frame_arb_if bus ();
    crc16_frame_arb #(
      .POLYNOMIAL ((g == 2) ? 16'h1021 : 16'h8005),
      .INIT_VALUE (16'hFFFF),
      .MAX_LEN    ((g == 1) ? 32'd4 : 32'd1024)
    ) dut (
      .clk_in (clk),
      .rst_n  (rst_n),
      .bus    (bus.master)
    );
    assign bus.in0_data  = in_data[g][0];
    assign bus.in0_valid = in_valid[g][0];
    assign bus.in0_last  = in_last[g][0];
    assign bus.in1_data  = in_data[g][1];
    assign bus.in1_valid = in_valid[g][1];
    assign bus.in1_last  = in_last[g][1];
    assign bus.out_ready = out_rdy[g];
    assign rdy[g][0]     = bus.in0_ready;
    assign rdy[g][1]     = bus.in1_ready;
    assign o_data[g]     = bus.out_data;
    assign o_valid[g]    = bus.out_valid;
    assign o_last[g]     = bus.out_last;
    assign o_chan[g]     = bus.out_chan;
    assign o_err[g]      = bus.err_trunc;
  end

  beat_t      src_q [NI][2][$];
  beat_t      exp_q [NI][2][$];
  obs_t       hist  [NI][$];
  logic [7:0] fbuf[$];
  int         got_trunc [NI];
  int         exp_trunc [NI];
  logic       bp        [NI];
  logic       in_frame  [NI];
  logic       cur_chan  [NI];
  logic       prev_stall[NI];
  logic [7:0] prev_data [NI];
  int         first_step[NI];
  int         step_cnt;
  int         checks;
  int         failures;

  function automatic int max_len(input int i);
    return (i == 1) ? 4 : 1024;
  endfunction

  function automatic logic [15:0] poly_of(input int i);
    return (i == 2) ? 16'h1021 : 16'h8005;
  endfunction

  // Serial polynomial division over the first k bytes of fbuf, one message bit at a time
  function automatic logic [15:0] model_crc(input int i, input int k);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int j = 0; j < k; j++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ fbuf[j][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ poly_of(i);
      end
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  task automatic send_frame(input int i, input int c);
    int          n;
    int          k;
    logic [15:0] fcs;
    n = fbuf.size();
    k = (n > max_len(i)) ? max_len(i) : n;
    for (int j = 0; j < n; j++) src_q[i][c].push_back('{fbuf[j], (j == n - 1)});
    for (int j = 0; j < k; j++) exp_q[i][c].push_back('{fbuf[j], 1'b0});
    fcs = ~model_crc(i, k);
    exp_q[i][c].push_back('{fcs[15:8], 1'b0});
    exp_q[i][c].push_back('{fcs[7:0], 1'b1});
    if (n > max_len(i)) exp_trunc[i]++;
  endtask

  task automatic load_ascii();
    fbuf.delete();
    for (int j = 0; j < 9; j++) fbuf.push_back(8'h31 + 8'(j));
  endtask

  task automatic load_random(input int n);
    fbuf.delete();
    for (int j = 0; j < n; j++) fbuf.push_back(8'($urandom));
  endtask

  // One clock: drive at negedge, observe the settled handshakes, advance past posedge
  task automatic step();
    obs_t  ob;
    beat_t e;
    logic  sf;
    for (int i = 0; i < NI; i++) begin
      out_rdy[i] = bp[i] ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int c = 0; c < 2; c++) begin
        if (src_q[i][c].size() > 0) begin
          in_valid[i][c] = 1'b1;
          in_data[i][c]  = src_q[i][c][0].data;
          in_last[i][c]  = src_q[i][c][0].last;
        end else begin
          in_valid[i][c] = 1'b0;
          in_data[i][c]  = 8'($urandom);
          in_last[i][c]  = 1'($urandom);
        end
      end
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      if (o_valid[i] && first_step[i] < 0) first_step[i] = step_cnt;
      if (prev_stall[i]) begin
        chk($sformatf("stall_valid[%0d]", i), 32'(o_valid[i]), 32'd1);
        chk($sformatf("stall_data[%0d]", i), 32'(o_data[i]), 32'(prev_data[i]));
      end
      prev_stall[i] = o_valid[i] && !out_rdy[i];
      prev_data[i]  = o_data[i];
      sf = !o_valid[i] || out_rdy[i];
      chk($sformatf("ready_exclusive[%0d]", i), 32'(rdy[i][0] && rdy[i][1]), 32'd0);
      if (i != 1) begin
        chk($sformatf("ready_without_slot[%0d]", i),
            32'((rdy[i][0] || rdy[i][1]) && !sf), 32'd0);
      end
      if (o_err[i]) got_trunc[i]++;
      for (int c = 0; c < 2; c++) begin
        if (in_valid[i][c] && rdy[i][c]) void'(src_q[i][c].pop_front());
      end
      if (o_valid[i] && out_rdy[i]) begin
        ob = '{o_data[i], o_last[i], o_chan[i]};
        hist[i].push_back(ob);
        if (in_frame[i]) chk($sformatf("no_interleave[%0d]", i), 32'(o_chan[i]), 32'(cur_chan[i]));
        if (exp_q[i][o_chan[i]].size() == 0) begin
          fail_now($sformatf("unexpected_out[%0d] data=0x%0h chan=%0d", i, o_data[i], o_chan[i]));
        end else begin
          e = exp_q[i][o_chan[i]].pop_front();
          chk($sformatf("out_data[%0d]", i), 32'(o_data[i]), 32'(e.data));
          chk($sformatf("out_last[%0d]", i), 32'(o_last[i]), 32'(e.last));
        end
        in_frame[i] = !o_last[i];
        cur_chan[i] = o_chan[i];
      end
    end
    @(posedge clk);
    @(negedge clk);
    step_cnt++;
  endtask

  function automatic logic busy();
    logic b;
    b = 1'b0;
    for (int i = 0; i < NI; i++) begin
      if (o_valid[i]) b = 1'b1;
      for (int c = 0; c < 2; c++) begin
        if (src_q[i][c].size() > 0 || exp_q[i][c].size() > 0) b = 1'b1;
      end
    end
    return b;
  endfunction

  task automatic run_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    if (busy()) fail_now($sformatf("timeout_%s", name));
    repeat (3) step();
  endtask

  task automatic flush();
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < 2; c++) begin
        src_q[i][c].delete();
        exp_q[i][c].delete();
        in_valid[i][c] = 1'b0;
        in_data[i][c]  = 8'h00;
        in_last[i][c]  = 1'b0;
      end
      hist[i].delete();
      out_rdy[i]    = 1'b1;
      bp[i]         = 1'b0;
      in_frame[i]   = 1'b0;
      cur_chan[i]   = 1'b0;
      prev_stall[i] = 1'b0;
      prev_data[i]  = 8'h00;
      first_step[i] = -1;
      got_trunc[i]  = 0;
      exp_trunc[i]  = 0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_out_valid[%0d]", tag, i), 32'(o_valid[i]), 32'd0);
      chk($sformatf("%s_out_data[%0d]", tag, i), 32'(o_data[i]), 32'd0);
      chk($sformatf("%s_out_last[%0d]", tag, i), 32'(o_last[i]), 32'd0);
      chk($sformatf("%s_out_chan[%0d]", tag, i), 32'(o_chan[i]), 32'd0);
      chk($sformatf("%s_err_trunc[%0d]", tag, i), 32'(o_err[i]), 32'd0);
      chk($sformatf("%s_ready[%0d]", tag, i), 32'({rdy[i][1], rdy[i][0]}), 32'd0);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vt[5];
    int   start;
    int   nfr;
    int   k;
    vt[0] = '{0, 1'b0, 1'b0, 8'h51, 8'h18};
    vt[1] = '{0, 1'b1, 1'b0, 8'h51, 8'h18};
    vt[2] = '{0, 1'b0, 1'b1, 8'h51, 8'h18};
    vt[3] = '{2, 1'b0, 1'b0, 8'hD6, 8'h4E};
    vt[4] = '{2, 1'b1, 1'b1, 8'hD6, 8'h4E};
    checks   = 0;
    failures = 0;
    step_cnt = 0;
    rst_n    = 1'b0;
    flush();
    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Tie arbitration right after reset: channel 0 wins first, then alternation
    for (int r = 0; r < 2; r++) begin
      load_random(3);
      send_frame(0, 0);
      load_random(3);
      send_frame(0, 1);
    end
    run_idle("tie", 200);
    k = 0;
    foreach (hist[0][j]) begin
      if (hist[0][j].last) begin
        if (k < 4) chk($sformatf("tie_order_frame%0d", k), 32'(hist[0][j].chan), 32'(k % 2));
        k++;
      end
    end
    chk("tie_frame_count", 32'(k), 32'd4);

    // Directed "123456789" frames: known CRC tails, first-output latency
    foreach (vt[v]) begin
      hist[vt[v].inst].delete();
      bp[vt[v].inst]         = vt[v].bp;
      first_step[vt[v].inst] = -1;
      start = step_cnt;
      load_ascii();
      send_frame(vt[v].inst, int'(vt[v].chan));
      run_idle($sformatf("vec%0d", v), 300);
      chk($sformatf("vec%0d_len", v), 32'(hist[vt[v].inst].size()), 32'd11);
      if (hist[vt[v].inst].size() == 11) begin
        chk($sformatf("vec%0d_crc_hi", v), 32'(hist[vt[v].inst][9].data), 32'(vt[v].hi));
        chk($sformatf("vec%0d_crc_lo", v), 32'(hist[vt[v].inst][10].data), 32'(vt[v].lo));
        chk($sformatf("vec%0d_hi_not_last", v), 32'(hist[vt[v].inst][9].last), 32'd0);
        chk($sformatf("vec%0d_lo_last", v), 32'(hist[vt[v].inst][10].last), 32'd1);
        chk($sformatf("vec%0d_chan", v), 32'(hist[vt[v].inst][10].chan), 32'(vt[v].chan));
      end
      chk($sformatf("vec%0d_first_latency", v), 32'(first_step[vt[v].inst] - start), 32'd2);
      bp[vt[v].inst] = 1'b0;
    end

    // Truncation at MAX_LEN=4 on channel 1, then a clean channel 0 frame
    hist[1].delete();
    got_trunc[1] = 0;
    exp_trunc[1] = 0;
    load_random(7);
    send_frame(1, 1);
    run_idle("trunc", 200);
    chk("trunc_pulses", 32'(got_trunc[1]), 32'd1);
    chk("trunc_out_len", 32'(hist[1].size()), 32'd6);
    chk("trunc_src_drained", 32'(src_q[1][1].size()), 32'd0);
    load_random(3);
    send_frame(1, 0);
    run_idle("after_trunc", 200);
    chk("after_trunc_len", 32'(hist[1].size()), 32'd11);
    chk("after_trunc_pulses", 32'(got_trunc[1]), 32'd1);

    // Randomized frames on all instances against the scoreboard
    for (int i = 0; i < NI; i++) begin
      got_trunc[i] = 0;
      exp_trunc[i] = 0;
    end
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < NI; i++) begin
        bp[i] = 1'($urandom_range(0, 1));
        nfr   = $urandom_range(1, 3);
        for (int f = 0; f < nfr; f++) begin
          load_random((i == 1) ? $urandom_range(1, 8) : $urandom_range(1, 12));
          send_frame(i, $urandom_range(0, 1));
        end
      end
      run_idle($sformatf("rand%0d", r), 2000);
    end
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rand_trunc_count[%0d]", i), 32'(got_trunc[i]), 32'(exp_trunc[i]));
      bp[i] = 1'b0;
    end

    // Reset while the CRC high byte is pending on a channel 1 frame
    hist[0].delete();
    load_ascii();
    send_frame(0, 1);
    k = 0;
    while (hist[0].size() < 8 && k < 50) begin
      step();
      k++;
    end
    if (hist[0].size() < 8) fail_now("timeout_reset_setup");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    flush();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_ascii();
    send_frame(0, 0);
    run_idle("after_reset", 300);
    chk("after_reset_len", 32'(hist[0].size()), 32'd11);
    if (hist[0].size() == 11) begin
      chk("after_reset_crc_hi", 32'(hist[0][9].data), 32'h51);
      chk("after_reset_crc_lo", 32'(hist[0][10].data), 32'h18);
      chk("after_reset_chan", 32'(hist[0][10].chan), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
